imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time controller that fills the CPU's 64-word instruction memory from a byte stream (UART/debug bridge), using a valid/ready handshake.
- Holds the core in reset while loading, and releases it only after the image is complete and its checksum is correct.
- Sits between the host byte source and the instruction memory write port.
- Owns the cpu_hold signal that gates the core.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory (depth = 2**ADDR_W words).
- TIMEOUT, 1000, idle cycles allowed between accepted bytes before aborting; must be >= 1.
- TO_W, 10, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_valid  input  1  rx_data is valid.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader can accept a byte.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_waddr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  holds the CPU in reset while 1.
- load_done  output  1  image loaded and verified.
- load_error  output  1  load aborted.
- err_code  output  2  abort cause: 00 none, 01 bad length, 10 checksum mismatch, 11 timeout.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Stream format, in order:
  - LEN byte L: number of words, 0..2**ADDR_W.
  - 4*L data bytes, little-endian per word.
  - CSUM byte: XOR of all data bytes only; LEN is excluded.
- A byte is accepted when rx_valid && rx_ready; at most one byte per cycle.
- All outputs are registered.
- Reset values: state IDLE, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, err_code=00, words_loaded=0.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: rx_ready=0, cpu_hold=1. start -> LEN.
- Entering LEN from any state:
  - clear byte counter, word address, XOR accumulator, timeout counter, words_loaded, load_done, load_error and err_code;
  - set cpu_hold=1.
- LEN: rx_ready=1. On accept:
  - L > 2**ADDR_W -> ERR with err_code=01.
  - L == 0 -> CSUM.
  - otherwise latch L and go to DATA.
- DATA: rx_ready=1.
  - Each accepted byte is shifted into bits [8k+7:8k] of the word (k = byte index 0..3) and XORed into the accumulator.
  - On the 4th byte, the next cycle has imem_we=1 for exactly one cycle, with imem_wdata = the assembled word and imem_waddr = the word index. The word index then increments, and words_loaded increments in the same cycle as the strobe.
  - After the L-th word's 4th byte -> CSUM.
  - Write latency: the strobe occurs 1 cycle after the 4th byte handshake.
- CSUM: rx_ready=1. On accept:
  - byte == accumulator -> DONE.
  - otherwise -> ERR with err_code=10.
- DONE: load_done=1, cpu_hold=0, rx_ready=0. Both load_done and the cpu_hold drop are visible 1 cycle after the CSUM handshake.
- ERR: load_error=1, cpu_hold=1, rx_ready=0.
- Timeout: in LEN, DATA and CSUM, a counter increments every cycle with no accept and clears on accept. When it reaches TIMEOUT -> ERR with err_code=11.
- start in LEN, DATA or CSUM is ignored.
- start in DONE or ERR restarts the load, re-asserting cpu_hold the next cycle.
- Simultaneous start and rx_valid in IDLE: the byte is not accepted, because rx_ready=0 that cycle.
- Word address wraps never: the length check guarantees a maximum index of 2**ADDR_W - 1.
- Reset mid-load:
  - returns to IDLE with the reset values;
  - any partial word is discarded;
  - words already written remain in memory;
  - cpu_hold stays 1.
- On any abort to ERR: words already written remain in memory; no further imem_we pulses occur.

Test Plan:
- Nominal 2-word load: start, then stream 02, 93 00 50 00, 13 01 A0 00, 71 -> imem_we pulses at addr 0 with 0x00500093 and addr 1 with 0x00A00113; then load_done=1, cpu_hold=0, words_loaded=2, err_code=00.
- Bad checksum: the same stream with final byte 70 -> two writes occur, then load_error=1, err_code=10, cpu_hold stays 1.
- Length bounds:
  - LEN=0x41 -> ERR with err_code=01, no writes.
  - LEN=0x00 followed by CSUM 00 -> DONE with words_loaded=0.
  - LEN=0x40 with 256 bytes -> the last write is at addr 63, then DONE.
- Backpressure and timeout:
  - rx_valid gaps of 5 cycles between bytes (TIMEOUT=1000) -> the result is identical to the nominal case.
  - Stopping after 3 data bytes -> ERR with err_code=11 exactly TIMEOUT cycles after the last accept, and no partial write.
- Reset and restart:
  - rst asserted after 6 data bytes -> IDLE, outputs at reset values, word 0 already written.
  - start from ERR with a fresh nominal stream -> DONE, with error flags cleared on entry to LEN.
- start pulsed during DATA -> ignored: the byte count and address continue unchanged.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and status signals of imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata,
    input  cpu_hold, load_done, load_error, err_code, words_loaded
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata,
    output cpu_hold, load_done, load_error, err_code, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a LEN/DATA/CSUM byte stream and
// keeps the CPU held in reset until the image is complete and verified.
module imem_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        acc_q, acc_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic accept;
  logic begin_load;
  logic [ADDR_W:0] wl_inc;

  assign accept = bus.rx_valid && rx_ready_q;
  assign wl_inc = wl_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    code_d     = code_q;
    wl_d       = wl_q;
    len_d      = len_q;
    bidx_d     = bidx_q;
    word_d     = word_q;
    acc_d      = acc_q;
    to_d       = to_q;
    begin_load = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin_load = 1'b1;
      end
      S_LEN: begin
        if (accept) begin
          if (32'(bus.rx_data) > DEPTH) begin
            state_d = S_ERR;
            code_d  = 2'b01;
          end else if (bus.rx_data == 8'h00) begin
            state_d = S_CSUM;
          end else begin
            len_d   = (ADDR_W+1)'(bus.rx_data);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          acc_d  = acc_q ^ bus.rx_data;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = {bus.rx_data, word_q};
              waddr_d = wl_q[ADDR_W-1:0];
              wl_d    = wl_inc;
              if (wl_inc == len_q) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.rx_data == acc_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            code_d  = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle-gap watchdog; the case above leaves receiving states untouched without an accept.
    if (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) begin
      if (accept) begin
        to_d = '0;
      end else if (to_q == TO_W'(TIMEOUT - 1)) begin
        state_d = S_ERR;
        code_d  = 2'b11;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    if (begin_load) begin
      state_d = S_LEN;
      bidx_d  = '0;
      waddr_d = '0;
      acc_d   = '0;
      to_d    = '0;
      wl_d    = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = 2'b00;
      hold_d  = 1'b1;
    end

    if (state_d == S_ERR) begin
      err_d  = 1'b1;
      hold_d = 1'b1;
    end

    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
      wl_q       <= '0;
      len_q      <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      wl_q       <= wl_d;
      len_q      <= len_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      to_q       <= to_d;
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_waddr   = waddr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.load_done    = done_q;
  assign bus.load_error   = err_q;
  assign bus.err_code     = code_q;
  assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads against a stream-level model.
module tb_imem_loader;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 1000;
  localparam int TO_W    = 10;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_we   = 0;
  logic [31:0] mem [DEPTH];
  logic [7:0] stream [$];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_waddr] = bus.imem_wdata;
      n_we++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string p);
    check({p, "_rx_ready"},   64'(bus.rx_ready),     64'(0));
    check({p, "_imem_we"},    64'(bus.imem_we),      64'(0));
    check({p, "_imem_waddr"}, 64'(bus.imem_waddr),   64'(0));
    check({p, "_imem_wdata"}, 64'(bus.imem_wdata),   64'(0));
    check({p, "_cpu_hold"},   64'(bus.cpu_hold),     64'(1));
    check({p, "_load_done"},  64'(bus.load_done),    64'(0));
    check({p, "_load_error"}, 64'(bus.load_error),   64'(0));
    check({p, "_err_code"},   64'(bus.err_code),     64'(0));
    check({p, "_words"},      64'(bus.words_loaded), 64'(0));
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $error("FAIL handshake: observed=no rx_ready required=rx_ready within 2000 cycles");
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic build(input int L, input bit good);
    logic [7:0] cs, b;
    stream.delete();
    stream.push_back(8'(L));
    if (L <= DEPTH) begin
      cs = '0;
      for (int i = 0; i < 4 * L; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        cs ^= b;
      end
      stream.push_back(good ? cs : cs ^ 8'(1 + $urandom_range(0, 254)));
    end
  endtask

  task automatic set_nominal(input logic [7:0] last);
    stream = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, last};
  endtask

  // Drives one complete load and checks strobes and final status against the stream rules.
  task automatic run_load(input string p, input logic [7:0] s[$], input int gap,
                          input int start_at, input bit overlap);
    int L, nw, we0, code;
    bit len_bad, good, ok;
    logic [7:0] cs;
    logic [31:0] word;
    L = int'(s[0]);
    len_bad = (L > DEPTH);
    nw = len_bad ? 0 : L;
    cs = '0;
    for (int i = 1; i <= 4 * nw; i++) cs ^= s[i];
    good = !len_bad && (s[4 * L + 1] == cs);
    code = len_bad ? 1 : (good ? 0 : 2);
    we0 = n_we;

    if (overlap) begin
      bus.start    = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[0];
      @(negedge clk);
      check({p, "_idle_start_ready"}, 64'(bus.rx_ready), 64'(0));
      @(posedge clk);
      #1 bus.start = 1'b0;
    end else begin
      do_start();
    end

    for (int i = 0; i < s.size(); i++) begin
      if (i == start_at) do_start();
      if (i > 0 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send_byte(s[i], ok);
      if (!ok) return;
      if (i >= 1 && !len_bad && i <= 4 * L && (i % 4) == 0) begin
        word = {s[i], s[i - 1], s[i - 2], s[i - 3]};
        @(negedge clk);
        check({p, "_we"},    64'(bus.imem_we),      64'(1));
        check({p, "_waddr"}, 64'(bus.imem_waddr),   64'(i / 4 - 1));
        check({p, "_wdata"}, 64'(bus.imem_wdata),   64'(word));
        check({p, "_wcnt"},  64'(bus.words_loaded), 64'(i / 4));
        @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    check({p, "_done"},     64'(bus.load_done),    64'(good));
    check({p, "_error"},    64'(bus.load_error),   64'(!good));
    check({p, "_err_code"}, 64'(bus.err_code),     64'(code));
    check({p, "_cpu_hold"}, 64'(bus.cpu_hold),     64'(!good));
    check({p, "_words"},    64'(bus.words_loaded), 64'(nw));
    check({p, "_rx_ready"}, 64'(bus.rx_ready),     64'(0));
    check({p, "_nwrites"},  64'(n_we - we0),       64'(nw));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we0, j;
    bit ok;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("rst");
    @(posedge clk);
    #1;

    // Nominal load, start coinciding with the LEN byte from IDLE.
    set_nominal(8'h71);
    run_load("nominal", stream, 0, -1, 1'b1);
    check("nominal_mem0", 64'(mem[0]), 64'(32'h00500093));
    check("nominal_mem1", 64'(mem[1]), 64'(32'h00A00113));

    set_nominal(8'h70);
    run_load("badcsum", stream, 0, -1, 1'b0);

    stream = '{8'h41};
    run_load("len41", stream, 0, -1, 1'b0);

    stream = '{8'h00, 8'h00};
    run_load("len0", stream, 0, -1, 1'b0);

    build(DEPTH, 1'b1);
    run_load("len40", stream, 0, -1, 1'b0);

    set_nominal(8'h71);
    run_load("gap5", stream, 5, -1, 1'b0);

    set_nominal(8'h71);
    run_load("start_in_data", stream, 0, 5, 1'b0);

    // Timeout after three data bytes: exact cycle count from the last accept.
    we0 = n_we;
    do_start();
    set_nominal(8'h71);
    for (int i = 0; i < 4; i++) send_byte(stream[i], ok);
    for (j = 0; j <= TIMEOUT + 5; j++) begin
      @(negedge clk);
      if (bus.load_error) break;
    end
    check("timeout_cycles",   64'(j),             64'(TIMEOUT));
    check("timeout_err_code", 64'(bus.err_code),  64'(3));
    check("timeout_cpu_hold", 64'(bus.cpu_hold),  64'(1));
    check("timeout_nwrites",  64'(n_we - we0),    64'(0));
    @(posedge clk);
    #1;

    // Restart from ERR clears flags on entry to LEN.
    do_start();
    @(negedge clk);
    check("restart_error",    64'(bus.load_error), 64'(0));
    check("restart_err_code", 64'(bus.err_code),   64'(0));
    check("restart_cpu_hold", 64'(bus.cpu_hold),   64'(1));
    check("restart_rx_ready", 64'(bus.rx_ready),   64'(1));
    @(posedge clk);
    #1;
    set_nominal(8'h71);
    run_load("restart", stream, 0, -1, 1'b0);

    // Reset after six data bytes keeps word 0 and discards the partial word.
    mem[0] = '0;
    we0 = n_we;
    do_start();
    set_nominal(8'h71);
    for (int i = 0; i < 7; i++) send_byte(stream[i], ok);
    @(negedge clk);
    check("midrst_mem0",    64'(mem[0]),      64'(32'h00500093));
    check("midrst_nwrites", 64'(n_we - we0),  64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    check("midrst_nwrites_after", 64'(n_we - we0), 64'(1));
    @(posedge clk);
    #1;

    // Random loads: mixed lengths, correct and corrupted checksums, random gaps.
    for (int r = 0; r < 8; r++) begin
      int L;
      L = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, 255))
                                       : int'($urandom_range(0, 12));
      build(L, $urandom_range(0, 3) != 0);
      run_load($sformatf("rand%0d", r), stream, int'($urandom_range(0, 3)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
